// File: rtl/sys_arr_pkg.sv
// Shared types, defaults and helpers for the sysArr tile sequencer.
package sys_arr_pkg;

    localparam int WIDTH_HEIGHT_DEF = 4;
    localparam int ADDR_W_DEF       = 8;
    localparam int ROW_W_DEF        = 8;
    localparam int LAT_MULT         = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sys_arr_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sys_arr_ctrl_cnt.sv
// Loadable up-counter with a terminal-count flag against a programmable last value.
module sys_arr_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    // Count register: load has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/sys_arr_ctrl.sv
// Tile sequencer for sysArr: weight load, activation feed, result write-back.
// Optional perf_cycles port and counter enabled by SYS_ARR_CTRL_PERF_EN.
module sys_arr_ctrl_chk #(
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             accept,
    input logic [ROW_W-1:0] num_rows
);

    a_rows_fit: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (64'(num_rows) <= (64'd1 << ADDR_W)));

endmodule

module sys_arr_ctrl
    import sys_arr_pkg::*;
#(
    parameter int width_height = WIDTH_HEIGHT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int ROW_W        = ROW_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ROW_W-1:0]        num_rows,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_rd_addr,
    output logic                    in_rd_en,
    output logic [ADDR_W-1:0]       in_rd_addr,
    output logic                    out_wr_en,
    output logic [ADDR_W-1:0]       out_wr_addr,
    output logic [width_height-1:0] wwrite,
    output logic                    active,
    output logic                    busy,
    output logic                    done
`ifdef SYS_ARR_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int LAT = LAT_MULT * width_height;
    // Low N-1 pipe stages extend active past the last read to flush the skew.
    localparam logic [LAT-1:0] ACT_MASK = LAT'((64'd1 << (width_height - 1)) - 64'd1);

    sys_arr_state_t   state_r, state_nx_s;
    logic [ROW_W-1:0] num_rows_r, rows_last_s;
    logic [LAT-1:0]   lat_pipe_r;
    logic             accept_s, ph_load_s, ph_en_s, ph_tc_s, out_load_s, out_tc_s;
    logic [ROW_W-1:0] ph_cnt_s, ph_last_s, out_cnt_s;

    assign accept_s    = (state_r == ST_IDLE) && start && !abort;
    assign rows_last_s = num_rows_r - ROW_W'(1);
    assign out_load_s  = abort || (state_r == ST_IDLE) || (state_r == ST_DONE);

    // Next-state and phase-counter control.
    always_comb begin
        state_nx_s = state_r;
        ph_en_s    = 1'b0;
        ph_last_s  = ROW_W'(width_height - 1);
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nx_s = start ? ST_LOAD_W : ST_IDLE;
                ST_LOAD_W: begin
                    ph_en_s = 1'b1;
                    if (ph_tc_s) begin
                        state_nx_s = (num_rows_r != {ROW_W{1'b0}}) ? ST_FEED : ST_DONE;
                    end else begin
                        state_nx_s = ST_LOAD_W;
                    end
                end
                ST_FEED: begin
                    ph_en_s    = 1'b1;
                    ph_last_s  = rows_last_s;
                    state_nx_s = ph_tc_s ? ST_DRAIN : ST_FEED;
                end
                ST_DRAIN:  state_nx_s = (lat_pipe_r[LAT-1] && out_tc_s) ? ST_DONE : ST_DRAIN;
                ST_DONE:   state_nx_s = ST_IDLE;
                default:   state_nx_s = ST_IDLE;
            endcase
        end
        ph_load_s = abort || (state_nx_s != state_r);
    end

    sys_arr_ctrl_cnt #(.W(ROW_W)) u_ph_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load_s),
        .load_val ({ROW_W{1'b0}}),
        .en       (ph_en_s),
        .last     (ph_last_s),
        .count    (ph_cnt_s),
        .tc       (ph_tc_s)
    );

    sys_arr_ctrl_cnt #(.W(ROW_W)) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (out_load_s),
        .load_val ({ROW_W{1'b0}}),
        .en       (lat_pipe_r[LAT-1]),
        .last     (rows_last_s),
        .count    (out_cnt_s),
        .tc       (out_tc_s)
    );

    sys_arr_ctrl_chk #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept_s),
        .num_rows (num_rows)
    );

    // State register and operation length latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            num_rows_r <= {ROW_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            num_rows_r <= accept_s ? num_rows : num_rows_r;
        end
    end

    // Registered strobes; wwrite/active/out_wr_en are delayed copies of the read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rd_en     <= 1'b0;
            w_rd_addr   <= {ADDR_W{1'b0}};
            in_rd_en    <= 1'b0;
            in_rd_addr  <= {ADDR_W{1'b0}};
            out_wr_en   <= 1'b0;
            out_wr_addr <= {ADDR_W{1'b0}};
            wwrite      <= {width_height{1'b0}};
            active      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lat_pipe_r  <= {LAT{1'b0}};
        end else if (abort) begin
            w_rd_en     <= 1'b0;
            w_rd_addr   <= {ADDR_W{1'b0}};
            in_rd_en    <= 1'b0;
            in_rd_addr  <= {ADDR_W{1'b0}};
            out_wr_en   <= 1'b0;
            out_wr_addr <= {ADDR_W{1'b0}};
            wwrite      <= {width_height{1'b0}};
            active      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lat_pipe_r  <= {LAT{1'b0}};
        end else begin
            w_rd_en     <= (state_r == ST_LOAD_W);
            w_rd_addr   <= (state_r == ST_LOAD_W) ? ADDR_W'(ph_cnt_s) : {ADDR_W{1'b0}};
            in_rd_en    <= (state_r == ST_FEED);
            in_rd_addr  <= (state_r == ST_FEED) ? ADDR_W'(ph_cnt_s) : {ADDR_W{1'b0}};
            out_wr_en   <= lat_pipe_r[LAT-1];
            out_wr_addr <= lat_pipe_r[LAT-1] ? ADDR_W'(out_cnt_s) : {ADDR_W{1'b0}};
            wwrite      <= {width_height{w_rd_en}};
            active      <= in_rd_en || ((lat_pipe_r & ACT_MASK) != {LAT{1'b0}});
            busy        <= (state_r != ST_IDLE);
            done        <= (state_r == ST_DONE);
            lat_pipe_r  <= {lat_pipe_r[LAT-2:0], in_rd_en};
        end
    end

`ifdef SYS_ARR_CTRL_PERF_EN
    logic [31:0] run_cnt_r;

    // Cycle count of the running operation, published when it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_r   <= 32'd0;
            perf_cycles <= 32'd0;
        end else if (abort || (state_r == ST_IDLE)) begin
            run_cnt_r   <= 32'd0;
            perf_cycles <= perf_cycles;
        end else begin
            run_cnt_r   <= sat_inc32(run_cnt_r);
            perf_cycles <= (state_r == ST_DONE) ? sat_inc32(run_cnt_r) : perf_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Scoreboard bench for sys_arr_ctrl (N=4): expected strobe events are queued per output and popped by a monitor.
module tb_sys_arr_ctrl;

    localparam int K_W = 0, K_WW = 1, K_IN = 2, K_ACT = 3, K_OUT = 4, K_BUSY = 5, K_DONE = 6;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] num_rows;
    logic       w_rd_en, in_rd_en, out_wr_en, active, busy, done;
    logic [7:0] w_rd_addr, in_rd_addr, out_wr_addr;
    logic [3:0] wwrite;
`ifdef SYS_ARR_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif
    logic [33:0] all_out;

    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    ev_t evq[7][$];

    sys_arr_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_rows    (num_rows),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .in_rd_en    (in_rd_en),
        .in_rd_addr  (in_rd_addr),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .wwrite      (wwrite),
        .active      (active),
        .busy        (busy),
        .done        (done)
`ifdef SYS_ARR_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    assign all_out = {w_rd_en, w_rd_addr, in_rd_en, in_rd_addr, out_wr_en, out_wr_addr,
                      wwrite, active, busy, done};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < 7; k++) s += evq[k].size();
        return s;
    endfunction

    task automatic check(string nm, logic [63:0] got, logic [63:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: cycle %0d got %0h required %0h", nm, cyc, got, req);
        end
    endtask

    task automatic push(int k, int c, int a, int cutoff);
        ev_t e;
        if (c <= cutoff) begin
            e.cyc  = c;
            e.addr = 8'(a);
            evq[k].push_back(e);
        end
    endtask

    // Hand-derived N=4 schedule relative to the start-sampling edge b.
    task automatic expect_op(int b, int r, int cutoff);
        int d;
        d = (r == 0) ? b + 5 : b + 14 + r;
        for (int i = 0; i < 4; i++) push(K_W, b + 1 + i, i, cutoff);
        for (int i = 0; i < 4; i++) push(K_WW, b + 2 + i, 15, cutoff);
        for (int i = 0; i < r; i++) push(K_IN, b + 5 + i, i, cutoff);
        if (r > 0) for (int i = 0; i < r + 3; i++) push(K_ACT, b + 6 + i, 0, cutoff);
        for (int i = 0; i < r; i++) push(K_OUT, b + 14 + i, i, cutoff);
        for (int c = b + 1; c <= d; c++) push(K_BUSY, c, 0, cutoff);
        push(K_DONE, d, 0, cutoff);
    endtask

    task automatic issue(int r, int cutoff_rel, output int b);
        @(negedge clk);
        start    = 1'b1;
        num_rows = 8'(r);
        b        = cyc + 1;
        expect_op(b, r, (cutoff_rel < 0) ? NEVER : b + cutoff_rel);
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_quiet(int maxc);
        int n = 0;
        while ((pending() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: %0d events still pending after %0d cycles, required 0", pending(), maxc);
            for (int k = 0; k < 7; k++) evq[k].delete();
        end
        @(negedge clk);
    endtask

    task automatic mon_kind(int k, string nm, logic stb, logic [7:0] a);
        ev_t e;
        if (stb) begin
            compared++;
            if (evq[k].size() == 0) begin
                mismatched++;
                $display("FAIL %s: high at cycle %0d addr %0d, required low", nm, cyc, a);
            end else begin
                e = evq[k].pop_front();
                if (e.cyc != cyc || e.addr !== a) begin
                    mismatched++;
                    $display("FAIL %s: got cycle %0d addr %0d, required cycle %0d addr %0d",
                             nm, cyc, a, e.cyc, e.addr);
                end
            end
        end else if (evq[k].size() != 0 && evq[k][0].cyc <= cyc) begin
            compared++;
            mismatched++;
            e = evq[k].pop_front();
            $display("FAIL %s: low at cycle %0d, required high at cycle %0d addr %0d",
                     nm, cyc, e.cyc, e.addr);
        end
    endtask

    // Monitor: compares every presented strobe against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            mon_kind(K_W,    "w_rd",   w_rd_en,   w_rd_addr);
            mon_kind(K_WW,   "wwrite", |wwrite,   {4'b0000, wwrite});
            mon_kind(K_IN,   "in_rd",  in_rd_en,  in_rd_addr);
            mon_kind(K_ACT,  "active", active,    8'd0);
            mon_kind(K_OUT,  "out_wr", out_wr_en, out_wr_addr);
            mon_kind(K_BUSY, "busy",   busy,      8'd0);
            mon_kind(K_DONE, "done",   done,      8'd0);
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed scenario sequence.
    initial begin
        int b;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        num_rows = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", all_out, 64'd0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("idle_outputs", all_out, 64'd0);
        end

        issue(0, -1, b);
        wait_quiet(40);
`ifdef SYS_ARR_CTRL_PERF_EN
        check("perf_weight_only", perf_cycles, 64'd5);
`endif

        issue(3, -1, b);
        wait_quiet(60);
`ifdef SYS_ARR_CTRL_PERF_EN
        check("perf_nominal", perf_cycles, 64'd17);
`endif

        issue(3, 9, b);
        while (cyc < b + 9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cycle", cyc, b + 10);
        check("abort_outputs", all_out, 64'd0);
        wait_quiet(60);
`ifdef SYS_ARR_CTRL_PERF_EN
        check("perf_after_abort", perf_cycles, 64'd17);
`endif
        issue(3, -1, b);
        wait_quiet(60);

        @(negedge clk);
        start    = 1'b1;
        abort    = 1'b1;
        num_rows = 8'd2;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        check("abort_beats_start", all_out, 64'd0);
        wait_quiet(10);

        issue(3, -1, b);
        while (cyc < b + 5) @(negedge clk);
        start    = 1'b1;
        num_rows = 8'd7;
        @(negedge clk);
        start    = 1'b0;
        wait_quiet(60);

        @(negedge clk);
        start    = 1'b1;
        num_rows = 8'd1;
        b        = cyc + 1;
        expect_op(b, 1, NEVER);
        expect_op(b + 16, 1, NEVER);
        expect_op(b + 32, 1, NEVER);
        while (cyc < b + 33) @(negedge clk);
        start = 1'b0;
        wait_quiet(100);

        issue(3, 7, b);
        while (cyc < b + 7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_out, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SYS_ARR_CTRL_PERF_EN
        check("perf_after_reset", perf_cycles, 64'd0);
`endif
        issue(3, -1, b);
        wait_quiet(60);

        check("leftover_events", pending(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
